gpio_irq_ctrl: RTL and testbench
================================

Name: gpio_irq_ctrl

Overview:
Parametrised multi-channel input port with an Avalon-MM slave and an interrupt output.
Each channel passes through a synchroniser and a programmable debounce filter. Each channel then has per-bit rising and/or falling edge detection into a write-1-to-clear capture register, with a per-bit interrupt mask.
It sits between external sensor/button interrupt pins and the system interconnect, and is the generalised successor of the single-bit edge-capture input ports.

Parameters:
WIDTH, 8, number of input channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_W, 8, width of per-channel debounce counter and limit register
DEBOUNCE_RST, 0, reset value of debounce limit register

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  asynchronous external inputs
readdata  out  32  registered read data
irq  out  1  interrupt request, active high

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - All sync flops, filtered state f, delayed state f_d, counters, rise_en, fall_en, irq_mask, edge_capture and readdata reset to 0.
  - debounce_limit resets to DEBOUNCE_RST.
  - irq=0.
  - Reset asserted mid-operation aborts any debounce count and clears all pending captures.
- Write: occurs when chipselect=1 and write_n=0. Register map (unused upper bits read 0, writes to RO addresses ignored):
  - 0: RO, filtered data f.
  - 1: RW, rise_en[WIDTH-1:0].
  - 2: RW, irq_mask[WIDTH-1:0].
  - 3: edge_capture; read returns the capture, write-1-to-clear per bit.
  - 4: RW, debounce_limit[DEBOUNCE_W-1:0].
  - 5: RW, fall_en[WIDTH-1:0].
  - 6: RO, pending = edge_capture & irq_mask.
  - 7: reads 0.
- Read: readdata is registered every clk from the current address, independent of chipselect. Read latency is 1 cycle.
- Synchroniser: s[i] is in_port[i] delayed by SYNC_STAGES flops.
- Debounce, per channel, each clk:
  - If s==f: cnt<=0.
  - Else if cnt>=debounce_limit: f<=s, cnt<=0.
  - Else: cnt<=cnt+1.
  - The counter saturates naturally by reset-on-update; no wrap is possible since cnt never exceeds the limit.
  - With limit=N, s must differ from f for N+1 consecutive clocks before f changes. A glitch shorter than that leaves f unchanged and resets cnt.
  - A limit change takes effect immediately. Comparison is >=, so lowering the limit below an in-flight cnt updates f on the next clock.
- Edge detect: f_d<=f each clk.
  - event[i] = (rise_en[i] & f[i] & ~f_d[i]) | (fall_en[i] & ~f[i] & f_d[i]).
  - With both enables set, either edge captures.
- Capture: edge_capture[i] is set on event[i] and cleared on a write to addr 3 with writedata[i]=1.
  - Simultaneous set and clear of the same bit: set wins, so no event is lost.
  - Clearing one bit never affects other bits.
- irq = |(edge_capture & irq_mask), combinational from registers.
  - Unmasking an already-set capture bit raises irq the cycle after the mask write.
- Latency: after an in_port transition, edge_capture is set SYNC_STAGES+debounce_limit+2 clocks later. With defaults (2 stages, limit 0) this is 4 clocks.
- Enables reset to 0, so inputs that are high at reset release produce a filtered rise but no capture.

Test Plan:
- Reset, then read all 8 addresses: each returns 0, except addr 4, which returns DEBOUNCE_RST. irq=0.
- Rise capture: rise_en=0x01, irq_mask=0x01, limit=0; in_port[0] 0->1.
  - Required: edge_capture bit0 and irq=1 exactly 4 clocks after the transition; addr 0 reads 0x01.
  - Then write 0x01 to addr 3: irq=0 the next cycle.
- Falling and both-edge: fall_en=0x02, rise_en=0x04; toggle bits 1 and 2 high then low.
  - Required: bit1 is captured only on the fall, bit2 only on the rise.
  - Then set rise_en=fall_en=0x08: bit3 captures on both edges.
- Debounce: limit=5; bit0 pulses high for 5 clocks, then later for 6 clocks.
  - Required: the first pulse gives no change in f and no capture. The second pulse gives f=1, with capture 2+5+2=9 clocks after the rising input edge.
- Simultaneous clear and event: schedule the addr 3 write of 0x01 on the same clock that bit0's event sets capture.
  - Required: bit0 remains 1 and irq stays high.
- Mask and pending: capture bits 0 and 4 with irq_mask=0.
  - Required: irq=0 and addr 6 reads 0.
  - Write irq_mask=0x10: irq=1 and addr 6 reads 0x10.
  - Assert reset_n mid-debounce: all capture bits clear and irq=0 immediately.

Source files
------------

// File: rtl/gpio_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// gpio_irq_ctrl_if
// Avalon-MM slave bus bundle for gpio_irq_ctrl.
//   address    : register word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : registered read data (32 bits), one cycle after address
// ---------------------------------------------------------------------------
interface gpio_irq_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_irq_ctrl
// Multi-channel interrupt-capable input port. Each channel is synchronised,
// debounced, then edge-detected (rising and/or falling) into a
// write-1-to-clear capture register; irq is the OR of masked captures.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (gpio_irq_ctrl_if.slave)
//   in_port      : asynchronous external inputs, WIDTH bits
//   irq          : interrupt request, active high
// Register map (word addresses):
//   0 RO filtered data   1 RW rise_en     2 RW irq_mask    3 W1C edge_capture
//   4 RW debounce_limit  5 RW fall_en     6 RO pending     7 reads 0
// ---------------------------------------------------------------------------
module gpio_irq_ctrl #(
    parameter int                    WIDTH        = 8,
    parameter int                    SYNC_STAGES  = 2,
    parameter int                    DEBOUNCE_W   = 8,
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_RST = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    gpio_irq_ctrl_if.slave    bus,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_RISE_EN  = 3'd1,
        REG_IRQ_MASK = 3'd2,
        REG_CAPTURE  = 3'd3,
        REG_DEBOUNCE = 3'd4,
        REG_FALL_EN  = 3'd5,
        REG_PENDING  = 3'd6,
        REG_RSVD     = 3'd7
    } reg_addr_e;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0][DEBOUNCE_W-1:0]  cnt;
    logic [WIDTH-1:0]                  f;
    logic [WIDTH-1:0]                  f_d;
    logic [WIDTH-1:0]                  rise_en;
    logic [WIDTH-1:0]                  fall_en;
    logic [WIDTH-1:0]                  irq_mask;
    logic [WIDTH-1:0]                  edge_capture;
    logic [DEBOUNCE_W-1:0]             debounce_limit;
    logic [WIDTH-1:0]                  edge_event;
    logic [WIDTH-1:0]                  clr_mask;
    logic [31:0]                       rd_mux;
    logic                              wr_en;
    reg_addr_e                         addr;

    // Upper writedata bits beyond WIDTH/DEBOUNCE_W are intentionally ignored.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    assign addr  = reg_addr_e'(bus.address);
    assign wr_en = bus.chipselect & ~bus.write_n;

    // ---------------- synchroniser ----------------
    // NOTE: every sequential block uses non-blocking (<=) assignments so all
    // flops sample their pre-edge inputs, which is what makes the shift chain
    // a real chain instead of collapsing into a single stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ---------------- debounce + edge history ----------------
    // A channel's count only grows while s disagrees with f and is cleared on
    // any agreement or update, so it can never pass the limit or wrap.
    // NOTE: the per-channel counters are ordinary flops, not a RAM, so they
    // are reset along with everything else; a reset aborts any count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            f   <= '0;
            f_d <= '0;
        end else begin
            f_d <= f;
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == f[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= debounce_limit) begin
                    f[i]   <= s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign edge_event = (rise_en & f & ~f_d) | (fall_en & ~f & f_d);

    assign clr_mask = (wr_en && addr == REG_CAPTURE) ? bus.writedata[WIDTH-1:0]
                                                      : '0;

    // ---------------- control registers and capture ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en        <= '0;
            fall_en        <= '0;
            irq_mask       <= '0;
            debounce_limit <= DEBOUNCE_RST;
            edge_capture   <= '0;
        end else begin
            // Clear first, then OR in new events: a same-cycle set wins.
            edge_capture <= (edge_capture & ~clr_mask) | edge_event;
            if (wr_en) begin
                case (addr)
                    REG_RISE_EN:  rise_en        <= bus.writedata[WIDTH-1:0];
                    REG_IRQ_MASK: irq_mask       <= bus.writedata[WIDTH-1:0];
                    REG_DEBOUNCE: debounce_limit <= bus.writedata[DEBOUNCE_W-1:0];
                    REG_FALL_EN:  fall_en        <= bus.writedata[WIDTH-1:0];
                    default:      ;
                endcase
            end
        end
    end

    // ---------------- read path ----------------
    // NOTE: rd_mux gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_DATA:     rd_mux = 32'(f);
            REG_RISE_EN:  rd_mux = 32'(rise_en);
            REG_IRQ_MASK: rd_mux = 32'(irq_mask);
            REG_CAPTURE:  rd_mux = 32'(edge_capture);
            REG_DEBOUNCE: rd_mux = 32'(debounce_limit);
            REG_FALL_EN:  rd_mux = 32'(fall_en);
            REG_PENDING:  rd_mux = 32'(edge_capture & irq_mask);
            REG_RSVD:     rd_mux = '0;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpio_irq_ctrl
// Self-checking bench for gpio_irq_ctrl. A behavioural model (input history
// queue, run-length debounce rule, capture/mask sets) is stepped once per
// clock alongside the DUT; irq and readdata are compared every cycle, and
// each scenario task adds its own directed checks.
// ---------------------------------------------------------------------------
module tb_gpio_irq_ctrl;
    localparam int                WIDTH = 8;
    localparam int                SYNC  = 2;
    localparam int                DW    = 8;
    localparam logic [DW-1:0]     DRST  = '0;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] in_port = '0;
    logic             irq;

    gpio_irq_ctrl_if bus_if();

    gpio_irq_ctrl #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC),
        .DEBOUNCE_W   (DW),
        .DEBOUNCE_RST (DRST)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] hist[$];       // in_port samples, newest first
    logic [WIDTH-1:0] m_f, m_fprev, m_cap, m_rise, m_fall, m_mask;
    int               m_run[WIDTH];  // consecutive clocks s has disagreed with f
    int               m_limit;
    logic [31:0]      m_rd;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back('0);
        m_f = '0; m_fprev = '0; m_cap = '0;
        m_rise = '0; m_fall = '0; m_mask = '0;
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        m_limit = int'(DRST);
        m_rd = '0;
    endfunction

    function automatic logic [31:0] read_val(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_f);
            3'd1:    return 32'(m_rise);
            3'd2:    return 32'(m_mask);
            3'd3:    return 32'(m_cap);
            3'd4:    return 32'(m_limit);
            3'd5:    return 32'(m_fall);
            3'd6:    return 32'(m_cap & m_mask);
            default: return 32'd0;
        endcase
    endfunction

    // One clock: step the model with the inputs present at the edge, then
    // compare irq and readdata shortly after the edge.
    task automatic tick();
        logic [WIDTH-1:0] s_now, ev, clr, nf;
        logic [31:0]      rd_next;
        logic             wr;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            hist.push_front(in_port);
            s_now = hist[SYNC];
            void'(hist.pop_back());
            rd_next = read_val(bus_if.address);
            wr  = bus_if.chipselect && !bus_if.write_n;
            clr = (wr && bus_if.address == 3'd3) ? bus_if.writedata[WIDTH-1:0] : '0;
            ev  = (m_rise & m_f & ~m_fprev) | (m_fall & ~m_f & m_fprev);
            nf  = m_f;
            for (int i = 0; i < WIDTH; i++) begin
                if (s_now[i] != m_f[i]) begin
                    m_run[i]++;
                    if (m_run[i] > m_limit) begin
                        nf[i] = s_now[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_fprev = m_f;
            m_f     = nf;
            m_cap   = (m_cap & ~clr) | ev;
            if (wr) begin
                case (bus_if.address)
                    3'd1: m_rise  = bus_if.writedata[WIDTH-1:0];
                    3'd2: m_mask  = bus_if.writedata[WIDTH-1:0];
                    3'd4: m_limit = int'(bus_if.writedata[DW-1:0]);
                    3'd5: m_fall  = bus_if.writedata[WIDTH-1:0];
                    default: ;
                endcase
            end
            m_rd = rd_next;
        end
        #1;
        checks++;
        if (irq !== |(m_cap & m_mask)) begin
            errors++;
            $display("FAIL model_irq: got %b expected %b at %0t", irq, |(m_cap & m_mask), $time);
        end
        checks++;
        if (bus_if.readdata !== m_rd) begin
            errors++;
            $display("FAIL model_readdata: got %h expected %h at %0t", bus_if.readdata, m_rd, $time);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus_if.address = a;
        tick();
        d = bus_if.readdata;
    endtask

    // Quiet all inputs and enables, let filters settle, clear every capture.
    task automatic quiesce();
        in_port = '0;
        bus_write(3'd1, 32'h0);
        bus_write(3'd5, 32'h0);
        bus_write(3'd4, 32'h0);
        ticks(8);
        bus_write(3'd3, 32'hFF);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d, exp;
        model_reset();
        ticks(3);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), d);
            exp = (a == 4) ? 32'(DRST) : 32'h0;
            checks++;
            if (d !== exp) begin
                errors++;
                $display("FAIL reset_read addr%0d: got %h expected %h", a, d, exp);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_rise();
        logic [31:0] d;
        int n;
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h01);
        bus_write(3'd4, 32'h0);
        in_port[0] = 1'b1;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (irq === 1'b1) break;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rise_latency: got %0d clocks expected 4", n);
        end
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h01) begin
            errors++;
            $display("FAIL rise_data: got %h expected 00000001", d);
        end
        bus_write(3'd3, 32'h01);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rise_clear_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_fall_both();
        logic [31:0] d;
        quiesce();
        bus_write(3'd5, 32'h02);
        bus_write(3'd1, 32'h04);
        in_port[2:1] = 2'b11;
        ticks(6);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h04) begin
            errors++;
            $display("FAIL fall_both_rise_phase: got %h expected 00000004", d);
        end
        bus_write(3'd3, 32'hFF);
        in_port[2:1] = 2'b00;
        ticks(6);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h02) begin
            errors++;
            $display("FAIL fall_both_fall_phase: got %h expected 00000002", d);
        end
        bus_write(3'd1, 32'h08);
        bus_write(3'd5, 32'h08);
        bus_write(3'd3, 32'hFF);
        in_port[3] = 1'b1;
        ticks(6);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h08) begin
            errors++;
            $display("FAIL both_edge_rise: got %h expected 00000008", d);
        end
        bus_write(3'd3, 32'hFF);
        in_port[3] = 1'b0;
        ticks(6);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h08) begin
            errors++;
            $display("FAIL both_edge_fall: got %h expected 00000008", d);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        int n;
        quiesce();
        bus_write(3'd4, 32'd5);
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h01);
        in_port[0] = 1'b1;
        ticks(5);
        in_port[0] = 1'b0;
        ticks(12);
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL debounce_glitch_data: got %h expected 00000000", d);
        end
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL debounce_glitch_capture: got %h expected 00000000", d);
        end
        in_port[0] = 1'b1;
        n = 0;
        while (n < 30) begin
            tick();
            n++;
            if (n == 6) in_port[0] = 1'b0;
            if (irq === 1'b1) break;
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL debounce_latency: got %0d clocks expected 9", n);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        quiesce();
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h01);
        in_port[0] = 1'b1;
        ticks(3);
        bus_write(3'd3, 32'h01);   // lands on the clock the capture sets
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL simul_irq: got %b expected 1", irq);
        end
        bus_read(3'd3, d);
        checks++;
        if (d[0] !== 1'b1) begin
            errors++;
            $display("FAIL simul_capture: got %b expected 1", d[0]);
        end
    endtask

    task automatic test_random();
        logic [2:0] a;
        logic [31:0] dat;
        quiesce();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                a   = 3'($urandom_range(0, 7));
                dat = (a == 3'd4) ? 32'($urandom_range(0, 3)) : $urandom;
                bus_write(a, dat);
            end else begin
                bus_if.address = 3'($urandom_range(0, 7));
                tick();
            end
            if ($urandom_range(0, 2) == 0)
                in_port = in_port ^ WIDTH'($urandom & $urandom);
        end
    endtask

    task automatic test_mask_pending_reset();
        logic [31:0] d;
        quiesce();
        bus_write(3'd2, 32'h00);
        bus_write(3'd1, 32'h11);
        in_port = 8'h11;
        ticks(6);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL masked_irq: got %b expected 0", irq);
        end
        bus_read(3'd6, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL masked_pending: got %h expected 00000000", d);
        end
        bus_write(3'd2, 32'h10);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL unmask_irq: got %b expected 1", irq);
        end
        bus_read(3'd6, d);
        checks++;
        if (d !== 32'h10) begin
            errors++;
            $display("FAIL unmask_pending: got %h expected 00000010", d);
        end
        bus_write(3'd4, 32'd10);
        in_port[5] = 1'b1;
        ticks(5);
        reset_n = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_irq: got %b expected 0", irq);
        end
        model_reset();
        ticks(2);
        reset_n = 1'b1;
        ticks(10);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_capture: got %h expected 00000000", d);
        end
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h31) begin
            errors++;
            $display("FAIL post_reset_data: got %h expected 00000031", d);
        end
    endtask

    initial begin
        bus_if.address    = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
        test_reset();
        test_rise();
        test_fall_both();
        test_debounce();
        test_simultaneous();
        test_random();
        test_mask_pending_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
